// File: rtl/mvm_pkg.sv
// Shared definitions for the banded matrix-vector engine: the state enum doubles as the
// opcode presented to the memory, so memory models and benches decode the same values.
package mvm_pkg;

  typedef enum logic [2:0] {
    ST_GET_N   = 3'd0,
    ST_GET_R   = 3'd1,
    ST_READ_A  = 3'd2,
    ST_READ_X  = 3'd3,
    ST_READ_B  = 3'd4,
    ST_WRITE_Y = 3'd5,
    ST_DONE    = 3'd6,
    ST_IDLE    = 3'd7
  } mvm_state_t;

  localparam logic [2:0] OP_GET_N   = 3'd0;
  localparam logic [2:0] OP_GET_R   = 3'd1;
  localparam logic [2:0] OP_READ_A  = 3'd2;
  localparam logic [2:0] OP_READ_X  = 3'd3;
  localparam logic [2:0] OP_READ_B  = 3'd4;
  localparam logic [2:0] OP_WRITE_Y = 3'd5;
  localparam logic [2:0] OP_DONE    = 3'd6;
  localparam logic [2:0] OP_IDLE    = 3'd7;

endpackage

// File: rtl/band_ctr.sv
// Row/column walker for a banded matrix: holds p and c, clips columns to the band and
// the matrix edge, and flags last column / last row. Moves only when told to.
module band_ctr #(
  parameter int IW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] i_n,
  input  logic [IW-1:0] i_r,
  input  logic          i_row_init,
  input  logic          i_col_inc,
  input  logic          i_row_next,
  output logic [IW-1:0] o_p,
  output logic [IW-1:0] o_c,
  output logic          o_last_col,
  output logic          o_last_row
);

  logic [IW-1:0] r_p;
  logic [IW-1:0] r_c;
  logic [IW-1:0] w_p_next;
  logic [IW-1:0] w_lo_next;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_nm1;
  logic [IW-1:0] w_hi;

  assign w_p_next  = r_p + 1'b1;
  assign w_lo_next = (w_p_next > i_r) ? (w_p_next - i_r) : '0;
  // p+r is one bit wider so a large r cannot wrap past the matrix edge
  assign w_sum     = {1'b0, r_p} + {1'b0, i_r};
  assign w_nm1     = i_n - 1'b1;
  assign w_hi      = (w_sum >= {1'b0, w_nm1}) ? w_nm1 : w_sum[IW-1:0];

  assign o_p        = r_p;
  assign o_c        = r_c;
  assign o_last_col = (r_c == w_hi);
  assign o_last_row = (r_p == w_nm1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p <= '0;
      r_c <= '0;
    end else if (i_row_init) begin
      r_p <= '0;
      r_c <= '0;
    end else if (i_col_inc) begin
      r_c <= r_c + 1'b1;
    end else if (i_row_next) begin
      r_p <= w_p_next;
      r_c <= w_lo_next;
    end
  end

endmodule

// File: rtl/banded_mvm.sv
// y = A*x + b over a banded n-by-n matrix, one memory transaction per state.
// Every memory state waits on mem_rdy; with mem_rdy low all state and outputs hold.
module banded_mvm
  import mvm_pkg::*;
#(
  parameter int DW  = 10,
  parameter int IW  = 10,
  parameter int OW  = 20,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mem_rdy,
  input  logic [DW-1:0] in_data,
  output logic [2:0]    opcode,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [OW-1:0] out_data,
  output logic          busy,
  output logic          fin
);

  localparam int AW = 2*DW + IW;

  mvm_state_t      r_state;
  logic [IW-1:0]   r_n;
  logic [IW-1:0]   r_r;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [AW-1:0]   r_acc;
  logic            r_busy;
  logic            r_fin;

  logic [IW-1:0]   w_p;
  logic [IW-1:0]   w_c;
  logic            w_last_col;
  logic            w_last_row;
  logic            w_row_init;
  logic            w_col_inc;
  logic            w_row_next;
  logic [2*DW-1:0] w_prod;
  logic [AW-1:0]   w_y;
  logic            w_ovf;
  logic [IW-1:0]   w_i;
  logic [IW-1:0]   w_j;

  assign w_row_init = (r_state == ST_GET_R) && mem_rdy;
  assign w_col_inc  = (r_state == ST_READ_X) && mem_rdy && !w_last_col;
  assign w_row_next = (r_state == ST_WRITE_Y) && mem_rdy;

  band_ctr #(.IW(IW)) u_band_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_n        (r_n),
    .i_r        (r_r),
    .i_row_init (w_row_init),
    .i_col_inc  (w_col_inc),
    .i_row_next (w_row_next),
    .o_p        (w_p),
    .o_c        (w_c),
    .o_last_col (w_last_col),
    .o_last_row (w_last_row)
  );

  assign w_prod = {{DW{1'b0}}, r_a} * {{DW{1'b0}}, in_data};

  // Output is built from registered acc and b, so it is stable for the whole WRITE_Y stall
  assign w_y      = r_acc + AW'(r_b);
  assign w_ovf    = |w_y[AW-1:OW];
  assign out_data = ((SAT != 0) && w_ovf) ? {OW{1'b1}} : w_y[OW-1:0];

  always_comb begin
    w_i = '0;
    w_j = '0;
    case (r_state)
      ST_READ_A: begin
        w_i = w_p;
        w_j = w_c;
      end
      ST_READ_X:             w_j = w_c;
      ST_READ_B, ST_WRITE_Y: w_i = w_p;
      default: ;
    endcase
  end

  assign opcode = r_state;
  assign i      = w_i;
  assign j      = w_j;
  assign busy   = r_busy;
  assign fin    = r_fin;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_r     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_fin   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_fin <= 1'b0;
          if (start) begin
            r_state <= ST_GET_N;
            r_busy  <= 1'b1;
          end
        end
        ST_GET_N: if (mem_rdy) begin
          r_n     <= IW'(in_data);
          r_state <= ST_GET_R;
        end
        ST_GET_R: if (mem_rdy) begin
          r_r   <= IW'(in_data);
          r_acc <= '0;
          if (r_n == '0) begin
            r_state <= ST_DONE;
            r_fin   <= 1'b1;
          end else begin
            r_state <= ST_READ_A;
          end
        end
        ST_READ_A: if (mem_rdy) begin
          r_a     <= in_data;
          r_state <= ST_READ_X;
        end
        ST_READ_X: if (mem_rdy) begin
          r_acc   <= r_acc + AW'(w_prod);
          r_state <= w_last_col ? ST_READ_B : ST_READ_A;
        end
        ST_READ_B: if (mem_rdy) begin
          r_b     <= in_data;
          r_state <= ST_WRITE_Y;
        end
        ST_WRITE_Y: if (mem_rdy) begin
          r_acc <= '0;
          if (w_last_row) begin
            r_state <= ST_DONE;
            r_fin   <= 1'b1;
          end else begin
            r_state <= ST_READ_A;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_fin   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_fin   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_banded_mvm.sv
// Bench for banded_mvm: behavioural memory + arithmetic reference, directed corner jobs
// and randomized jobs; a SAT=1 and a SAT=0 instance share the same memory stimulus.
module tb_banded_mvm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mem_rdy;
  logic [9:0]  in_data;
  logic [2:0]  opcode,   op_t;
  logic [9:0]  i, j,     i_t, j_t;
  logic [19:0] out_data, out_t;
  logic        busy, fin, busy_t, fin_t;

  int A [16][16];
  int X [16];
  int B [16];
  int nn, rr;
  int n_chk = 0;
  int n_bad = 0;
  int last_y[$];
  int last_t[$];

  always #5 clk = ~clk;

  banded_mvm #(.DW(10), .IW(10), .OW(20), .SAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_rdy(mem_rdy), .in_data(in_data),
    .opcode(opcode), .i(i), .j(j), .out_data(out_data), .busy(busy), .fin(fin)
  );

  banded_mvm #(.DW(10), .IW(10), .OW(20), .SAT(0)) dut_t (
    .clk(clk), .reset(reset), .start(start), .mem_rdy(mem_rdy), .in_data(in_data),
    .opcode(op_t), .i(i_t), .j(j_t), .out_data(out_t), .busy(busy_t), .fin(fin_t)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_data();
    in_data = '0;
    case (opcode)
      3'd0: in_data = 10'(nn);
      3'd1: in_data = 10'(rr);
      3'd2: if (i < 16 && j < 16) in_data = 10'(A[i][j]);
      3'd3: if (j < 16) in_data = 10'(X[j]);
      3'd4: if (i < 16) in_data = 10'(B[i]);
      default: ;
    endcase
  endtask

  task automatic run_job(input int n_, input int r_, input int stall_row, input int rst_row,
                         input bit glitch, input bit rnd_rdy);
    int cyc, t_getr, t_done, fins, cur_row, viol, badop, op, si, sj, lo, hi, ecyc;
    bit aborted, stalled;
    int got_y[$];
    int got_t[$];
    int got_row[$];
    int seq[$];
    longint s, ey, et;
    nn = n_; rr = r_;
    cyc = 0; t_getr = -1; t_done = -1; fins = 0; cur_row = -1; viol = 0; badop = 0;
    aborted = 0; stalled = 0;
    @(negedge clk); start = 1'b1; mem_rdy = 1'b1;
    @(negedge clk); start = 1'b0;
    while (1) begin
      op = int'(opcode);
      if (cyc > 3000) begin
        chk("timeout", 1, 0);
        break;
      end
      seq.push_back(op);
      if (fin) fins++;
      if (op == 7) break;
      if (op >= 2 && op <= 5 && (i >= 10'(nn) || j >= 10'(nn))) viol++;
      if (op == 2) cur_row = int'(i);
      if (rst_row >= 0 && op == 2 && cur_row == rst_row) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_op", opcode, 7);
        chk("rst_busy", busy, 0);
        chk("rst_i", i, 0);
        chk("rst_j", j, 0);
        chk("rst_fin", fin, 0);
        aborted = 1;
        break;
      end
      if (stall_row >= 0 && !stalled && op == 3 && cur_row == stall_row) begin
        si = int'(i); sj = int'(j);
        mem_rdy = 1'b0; stalled = 1;
        repeat (3) begin
          @(negedge clk);
          chk("stall_op", opcode, 3);
          chk("stall_i", i, si);
          chk("stall_j", j, sj);
        end
        cyc += 3;
      end
      mem_rdy = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
      drive_data();
      start = glitch && (op == 3 || op == 6);
      if (op == 1 && mem_rdy) t_getr = cyc;
      if (op == 6 && t_done < 0) t_done = cyc;
      if (op == 5 && mem_rdy) begin
        got_y.push_back(int'(out_data));
        got_t.push_back(int'(out_t));
        got_row.push_back(int'(i));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; mem_rdy = 1'b1;
    if (aborted) return;
    repeat (3) @(negedge clk);
    chk("idle_after", opcode, 7);
    chk("fin_cnt", fins, 1);
    chk("range", viol, 0);
    chk("n_writes", got_y.size(), nn);
    ecyc = 0;
    for (int p = 0; p < nn; p++) begin
      lo = (p - rr < 0) ? 0 : p - rr;
      hi = (p + rr > nn - 1) ? nn - 1 : p + rr;
      s = B[p];
      for (int c = lo; c <= hi; c++) s += longint'(A[p][c]) * longint'(X[c]);
      ey = (s > 1048575) ? 1048575 : s;
      et = s % 1048576;
      ecyc += 2 * (hi - lo + 1) + 2;
      if (p < got_y.size()) begin
        chk("y_sat", got_y[p], ey);
        chk("y_trunc", got_t[p], et);
        chk("y_row", got_row[p], p);
      end
    end
    if (!rnd_rdy && stall_row < 0) chk("cycles", t_done - t_getr - 1, ecyc);
    if (nn == 0) begin
      foreach (seq[k]) if (seq[k] >= 2 && seq[k] <= 5) badop++;
      chk("n0_ops", badop, 0);
      chk("n0_len", seq.size(), 4);
    end
    last_y = got_y;
    last_t = got_t;
  endtask

  task automatic load_tri();
    for (int p = 0; p < 16; p++) begin
      for (int c = 0; c < 16; c++) A[p][c] = 2;
      X[p] = p + 1;
      B[p] = 1;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_rdy = 1'b1; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_op", opcode, 7);
    chk("reset_busy", busy, 0);
    chk("reset_fin", fin, 0);
    chk("reset_ij", {i, j}, 0);
    chk("reset_out", out_data, 0);
    reset = 1'b0;

    load_tri();
    run_job(3, 1, -1, -1, 0, 0);
    if (last_y.size() == 3) begin
      chk("tri_y0", last_y[0], 7);
      chk("tri_y1", last_y[1], 13);
      chk("tri_y2", last_y[2], 11);
    end else chk("tri_size", last_y.size(), 3);

    for (int p = 0; p < 16; p++) begin
      for (int c = 0; c < 16; c++) A[p][c] = 1023;
      X[p] = 1023;
      B[p] = 0;
    end
    run_job(2, 1, -1, -1, 0, 0);
    if (last_y.size() == 2) begin
      chk("ovf_sat", last_y[1], 1048575);
      chk("ovf_trunc", last_t[1], 1044482);
    end else chk("ovf_size", last_y.size(), 2);

    load_tri();
    run_job(3, 1, 1, -1, 0, 0);
    run_job(0, 2, -1, -1, 0, 0);
    run_job(3, 1, -1, 1, 0, 0);
    run_job(3, 1, -1, -1, 0, 0);
    run_job(3, 1, -1, -1, 1, 0);
    run_job(4, 9, -1, -1, 0, 0);

    for (int t = 0; t < 6; t++) begin
      int rn;
      rn = int'($urandom_range(9, 1));
      for (int p = 0; p < 16; p++) begin
        for (int c = 0; c < 16; c++) A[p][c] = int'($urandom_range(1023));
        X[p] = int'($urandom_range(1023));
        B[p] = int'($urandom_range(1023));
      end
      run_job(rn, int'($urandom_range(rn + 1)), -1, -1, t[0], t[1]);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
